mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single slow off-chip memory port between the I-cache and D-cache refill/writeback interfaces.
- Sits between the two cache instances and the external memory model, and replaces their separate memory ports.
- Grants one cache at a time for a whole line transaction, arbitrating round-robin on contention.
- Carries a saturating contention counter for performance debug.

Parameters:
- ADDR_W, 28, line address width (byte address bits 31:4).
- LINE_W, 128, cache line width in bits.
- CNT_W, 16, width of the contention counter.

Ports:
- clk  input  1  system clock
- proc_reset  input  1  asynchronous active-high reset
- i_read  input  1  I-cache line read request
- i_write  input  1  I-cache line write request
- i_addr  input  ADDR_W  I-cache line address
- i_wdata  input  LINE_W  I-cache write line
- i_rdata  output  LINE_W  read line returned to I-cache
- i_ready  output  1  transaction-done pulse to I-cache
- d_read  input  1  D-cache line read request
- d_write  input  1  D-cache line write request
- d_addr  input  ADDR_W  D-cache line address
- d_wdata  input  LINE_W  D-cache write line
- d_rdata  output  LINE_W  read line returned to D-cache
- d_ready  output  1  transaction-done pulse to D-cache
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- mem_addr  output  ADDR_W  memory line address
- mem_wdata  output  LINE_W  memory write line
- mem_rdata  input  LINE_W  memory read line
- mem_ready  input  1  memory done, one-cycle pulse
- conflict_cnt  output  CNT_W  cycles in which both caches requested while IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset proc_reset is asynchronous and active-high.
- Request definition: req_i = i_read|i_write; req_d = d_read|d_write. A cache holds its request and address/data stable until it sees its ready.
- State machine: IDLE, OWN_I, OWN_D. Registered state, plus a 1-bit last_owner register (0=I, 1=D).
- IDLE transitions:
  - only req_i -> OWN_I; only req_d -> OWN_D; no request -> stay IDLE.
  - both requesting -> grant the side that is not last_owner; conflict_cnt += 1, saturating at all-ones.
- Grant takes effect the cycle after the request is seen (one-cycle arbitration latency). No memory strobe is issued from IDLE.
- OWN_x outputs:
  - mem_read/mem_write/mem_addr/mem_wdata combinationally equal owner's signals.
  - x_ready = mem_ready; other side's ready = 0.
  - On mem_ready=1: next state IDLE, last_owner <= x.
- Outside OWN states: mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0, i_ready = d_ready = 0.
- i_rdata and d_rdata both equal mem_rdata at all times (broadcast). Only the owner's ready qualifies it.
- The mandatory IDLE cycle after each completion lets the finished cache drop or re-issue its request. A writeback followed by an allocate from the same cache re-arbitrates, so the other cache can interleave.
- Owner drops its request before mem_ready (protocol violation): stay in OWN_x and forward the dropped strobes. No recovery is required. The bench must not generate this.
- Mutual exclusion: a cache asserting read and write together is forwarded as-is; the arbiter does not check it.
- mem_ready while IDLE: ignored, no ready is routed to either cache.
- Reset values: state = IDLE, last_owner = 1 (first tie goes to I), conflict_cnt = 0. All outputs go to 0 immediately on proc_reset assertion, including mid-transaction. Any in-flight memory transaction is abandoned.
- Worst-case latency per requester: one full transaction of the other cache plus 2 cycles of arbitration overhead. No starvation.

Test Plan:
- Single I read, addr 0x0000010, memory ready after 5 cycles with data 0xA5..A5:
  - mem_read rises 1 cycle after i_read.
  - i_ready pulses once with i_rdata = 0xA5..A5; d_ready stays 0.
  - State back to IDLE the next cycle.
- Simultaneous d_write (addr 0x0000020) and i_read right after reset:
  - I granted first; D served after I's mem_ready plus 1 IDLE cycle.
  - mem_addr sequence is 0x10 then 0x20; conflict_cnt = 1.
- Back-to-back contention over 4 transactions with both caches always requesting: grants alternate I, D, I, D; conflict_cnt = 4.
- D writeback then D allocate while I waits: after D's writeback completes, I is granted before D's allocate read.
- proc_reset asserted mid-transaction while in OWN_D:
  - mem_read, mem_write and d_ready drop to 0 in the same cycle; conflict_cnt = 0.
  - After release, a new d_read is granted normally.
- mem_ready pulse while IDLE with no requests: no i_ready/d_ready pulse, state unchanged. Also cover conflict_cnt saturation with CNT_W = 2 forced: 5 conflicts -> value 3.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side line transaction signals.
// The arbiter connects through the slave modport; the environment
// (caches plus memory model) drives the master side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    // I-cache side
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_wdata;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;
    // D-cache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;
    // memory side
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    // caches and memory model
    modport master (
        output i_read, i_write, i_addr, i_wdata,
        output d_read, d_write, d_addr, d_wdata,
        output mem_rdata, mem_ready,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );

    // arbiter
    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        input  d_read, d_write, d_addr, d_wdata,
        input  mem_rdata, mem_ready,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one off-chip memory port between the I-cache and D-cache.
// A grant covers a whole line transaction; ties are broken round-robin
// against the previous owner. Every completion returns through IDLE so the
// finished cache can drop or re-issue and the other side gets a chance.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             proc_reset,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] conflict_cnt
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_owner;   // 0 = I-cache finished last, 1 = D-cache
    logic   req_i, req_d, both_req;

    assign req_i    = bus.i_read | bus.i_write;
    assign req_d    = bus.d_read | bus.d_write;
    assign both_req = (state == IDLE) && req_i && req_d;

    // state, round-robin pointer and contention counter
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state        <= IDLE;
            last_owner   <= 1'b1;        // first tie goes to the I-cache
            conflict_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == OWN_I && bus.mem_ready) last_owner <= 1'b0;
            if (state == OWN_D && bus.mem_ready) last_owner <= 1'b1;
            if (both_req && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

    // next state and memory/cache routing for the current owner
    always_comb begin
        state_nxt     = state;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.i_ready   = 1'b0;
        bus.d_ready   = 1'b0;
        // read data is broadcast; only the owner's ready qualifies it
        bus.i_rdata   = proc_reset ? '0 : bus.mem_rdata;
        bus.d_rdata   = proc_reset ? '0 : bus.mem_rdata;
        case (state)
            IDLE: begin
                // grant lands next cycle; no strobe is issued from IDLE and
                // a stray mem_ready here is dropped
                if (req_i && req_d) state_nxt = last_owner ? OWN_I : OWN_D;
                else if (req_i)     state_nxt = OWN_I;
                else if (req_d)     state_nxt = OWN_D;
            end
            OWN_I: begin
                bus.mem_read  = bus.i_read;
                bus.mem_write = bus.i_write;
                bus.mem_addr  = bus.i_addr;
                bus.mem_wdata = bus.i_wdata;
                bus.i_ready   = bus.mem_ready;
                if (bus.mem_ready) state_nxt = IDLE;
            end
            OWN_D: begin
                bus.mem_read  = bus.d_read;
                bus.mem_write = bus.d_write;
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.d_ready   = bus.mem_ready;
                if (bus.mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int ADDR_W = 28;
  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic proc_reset;
  logic [15:0] cnt;
  logic [1:0]  cnt2;
  int vectors = 0;
  int miscompares = 0;

  localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_WB = {4{32'hDEADBEEF}};

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus2 ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(16)) dut (
    .clk(clk), .proc_reset(proc_reset), .bus(bus.slave), .conflict_cnt(cnt)
  );
  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(2)) dut_sat (
    .clk(clk), .proc_reset(proc_reset), .bus(bus2.slave), .conflict_cnt(cnt2)
  );

  assign bus2.i_read    = bus.i_read;
  assign bus2.i_write   = bus.i_write;
  assign bus2.i_addr    = bus.i_addr;
  assign bus2.i_wdata   = bus.i_wdata;
  assign bus2.d_read    = bus.d_read;
  assign bus2.d_write   = bus.d_write;
  assign bus2.d_addr    = bus.d_addr;
  assign bus2.d_wdata   = bus.d_wdata;
  assign bus2.mem_rdata = bus.mem_rdata;
  assign bus2.mem_ready = bus.mem_ready;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_contention(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      bus.mem_ready = 1'b1;
      @(negedge clk);
      chk("rr_mem_read", bus.mem_read, 1'b1);
      chk("rr_addr", bus.mem_addr, ((k % 2) == 0) ? 28'h30 : 28'h40);
      chk("rr_i_ready", bus.i_ready, ((k % 2) == 0) ? 1'b1 : 1'b0);
      chk("rr_d_ready", bus.d_ready, ((k % 2) == 0) ? 1'b0 : 1'b1);
      step();
      bus.mem_ready = 1'b0;
      if (k == n - 1) begin
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
      end
      @(negedge clk);
      chk("rr_idle_gap", bus.mem_read, 1'b0);
    end
  endtask

  initial begin
    bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 0;
    proc_reset = 1'b1;

    @(negedge clk);
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_cnt", cnt, 16'd0);
    chk("rst_cnt_sat", cnt2, 2'd0);
    step();
    proc_reset = 1'b0;

    bus.i_read = 1'b1; bus.i_addr = 28'h10;
    @(negedge clk);
    chk("t1_no_strobe_idle", bus.mem_read, 1'b0);
    step();
    @(negedge clk);
    chk("t1_mem_read", bus.mem_read, 1'b1);
    chk("t1_mem_addr", bus.mem_addr, 28'h10);
    repeat (4) begin
      step();
      @(negedge clk);
      chk("t1_wait_i_ready", bus.i_ready, 1'b0);
    end
    step();
    bus.mem_ready = 1'b1; bus.mem_rdata = LINE_A5;
    @(negedge clk);
    chk("t1_i_ready", bus.i_ready, 1'b1);
    chk("t1_i_rdata", bus.i_rdata, LINE_A5);
    chk("t1_d_ready", bus.d_ready, 1'b0);
    step();
    bus.mem_ready = 1'b0; bus.i_read = 1'b0;
    @(negedge clk);
    chk("t1_back_idle", bus.mem_read, 1'b0);
    chk("t1_i_ready_low", bus.i_ready, 1'b0);

    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_rdy_i", bus.i_ready, 1'b0);
    chk("idle_rdy_d", bus.d_ready, 1'b0);
    chk("idle_rdy_strobe", bus.mem_read | bus.mem_write, 1'b0);
    step();
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("idle_rdy_stay", bus.mem_read | bus.mem_write, 1'b0);

    proc_reset = 1'b1;
    step();
    proc_reset = 1'b0;
    bus.i_read = 1'b1;  bus.i_addr = 28'h10;
    bus.d_write = 1'b1; bus.d_addr = 28'h20; bus.d_wdata = LINE_WB;
    @(negedge clk);
    chk("t2_idle_no_write", bus.mem_write, 1'b0);
    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("t2_first_addr", bus.mem_addr, 28'h10);
    chk("t2_first_read", bus.mem_read, 1'b1);
    chk("t2_first_nowrite", bus.mem_write, 1'b0);
    chk("t2_i_ready", bus.i_ready, 1'b1);
    chk("t2_cnt", cnt, 16'd1);
    step();
    bus.mem_ready = 1'b0; bus.i_read = 1'b0;
    @(negedge clk);
    chk("t2_gap", bus.mem_write, 1'b0);
    chk("t2_gap_addr", bus.mem_addr, 28'h0);
    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("t2_second_addr", bus.mem_addr, 28'h20);
    chk("t2_second_write", bus.mem_write, 1'b1);
    chk("t2_wdata", bus.mem_wdata, LINE_WB);
    chk("t2_d_ready", bus.d_ready, 1'b1);
    chk("t2_i_quiet", bus.i_ready, 1'b0);
    step();
    bus.mem_ready = 1'b0; bus.d_write = 1'b0;
    @(negedge clk);
    chk("t2_cnt_final", cnt, 16'd1);

    proc_reset = 1'b1;
    step();
    proc_reset = 1'b0;
    bus.i_read = 1'b1; bus.i_addr = 28'h30;
    bus.d_read = 1'b1; bus.d_addr = 28'h40;
    run_contention(4);
    chk("t3_cnt", cnt, 16'd4);

    bus.d_write = 1'b1; bus.d_addr = 28'h50;
    step();
    bus.i_read = 1'b1; bus.i_addr = 28'h60;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("t4_wb_write", bus.mem_write, 1'b1);
    chk("t4_wb_addr", bus.mem_addr, 28'h50);
    chk("t4_wb_ready", bus.d_ready, 1'b1);
    step();
    bus.mem_ready = 1'b0;
    bus.d_write = 1'b0; bus.d_read = 1'b1; bus.d_addr = 28'h70;
    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("t4_i_before_alloc", bus.mem_addr, 28'h60);
    chk("t4_i_ready", bus.i_ready, 1'b1);
    chk("t4_cnt", cnt, 16'd5);
    step();
    bus.mem_ready = 1'b0; bus.i_read = 1'b0;
    step();
    @(negedge clk);
    chk("t4_alloc_addr", bus.mem_addr, 28'h70);
    chk("t4_alloc_read", bus.mem_read, 1'b1);

    step();
    bus.mem_ready = 1'b1;
    #1;
    chk("t5_pre_d_ready", bus.d_ready, 1'b1);
    proc_reset = 1'b1;
    #1;
    chk("t5_mem_read", bus.mem_read, 1'b0);
    chk("t5_mem_write", bus.mem_write, 1'b0);
    chk("t5_d_ready", bus.d_ready, 1'b0);
    chk("t5_d_rdata", bus.d_rdata, {LINE_W{1'b0}});
    chk("t5_cnt", cnt, 16'd0);
    bus.mem_ready = 1'b0;
    step();
    proc_reset = 1'b0;
    bus.d_addr = 28'h80;
    @(negedge clk);
    chk("t5_idle_after", bus.mem_read, 1'b0);
    step();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("t5_regrant_read", bus.mem_read, 1'b1);
    chk("t5_regrant_addr", bus.mem_addr, 28'h80);
    chk("t5_regrant_ready", bus.d_ready, 1'b1);
    step();
    bus.mem_ready = 1'b0; bus.d_read = 1'b0;

    bus.i_read = 1'b1; bus.i_addr = 28'h30;
    bus.d_read = 1'b1; bus.d_addr = 28'h40;
    run_contention(5);
    chk("t6_cnt", cnt, 16'd5);
    chk("t6_cnt_sat", cnt2, 2'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
